// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with runtime frame format, 3-sample majority vote,
// false-start/framing/break/overrun detection and a status-tagged RX FIFO.
module uart_rx_ext #(
   parameter int unsigned MAX_WIDTH   = 9,
   parameter int unsigned SAMPLE_RATE = 16,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           cfg_data_bits,
   input  logic [2:0]           cfg_parity,
   input  logic [1:0]           cfg_stop_bits,
   input  logic [15:0]          cfg_clk_div,
   input  logic                 uart_rx,
   input  logic                 rx_req,
   output logic [MAX_WIDTH-1:0] rx_data,
   output logic                 rx_ready,
   output logic                 parity_err,
   output logic                 framing_err,
   output logic                 break_det,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int unsigned PW = $clog2(SAMPLE_RATE);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned EW = MAX_WIDTH + 2;
   localparam logic [PW-1:0] PH_LO  = PW'(SAMPLE_RATE / 2 - 1);
   localparam logic [PW-1:0] PH_MID = PW'(SAMPLE_RATE / 2);
   localparam logic [PW-1:0] PH_HI  = PW'(SAMPLE_RATE / 2 + 1);
   localparam logic [PW-1:0] PH_END = PW'(SAMPLE_RATE - 1);
   localparam logic [3:0]    NB_MAX = 4'(MAX_WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
   typedef enum logic [2:0] {
      P_NONE = 3'd0, P_EVEN = 3'd1, P_ODD = 3'd2, P_MARK = 3'd3, P_SPACE = 3'd4
   } par_t;

   state_t               state;
   par_t                 par_l;
   logic                 sync1, sync2, prev;
   logic [15:0]          div_cnt, div_l;
   logic [PW-1:0]        phase;
   logic                 s_lo, s_mid;
   logic [3:0]           nb_l, bit_idx, nb_c;
   logic                 two_stop_l, stop_idx, ferr_acc, perr_l, par_zero;
   logic [MAX_WIDTH-1:0] data_sh;
   logic                 tick, decide, vote, stop_last, brk_now, push;
   logic [EW-1:0]        push_word;

   logic [EW-1:0]        mem [FIFO_DEPTH];
   logic [EW-1:0]        head;
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic                 full, pop, push_ok;

   always_comb begin
      nb_c      = (cfg_data_bits < 4'd5) ? 4'd5 :
                  (cfg_data_bits > NB_MAX) ? NB_MAX : cfg_data_bits;
      tick      = (div_cnt == div_l - 16'd1);
      decide    = tick && (phase == PH_HI);
      vote      = (s_lo & s_mid) | (s_lo & sync2) | (s_mid & sync2);
      stop_last = !two_stop_l || stop_idx;
      // Break is judged on the first stop bit so a long low line never pushes a word.
      brk_now   = decide && (state == S_STOP) && !stop_idx && !vote &&
                  (data_sh == '0) && par_zero;
      push      = decide && (state == S_STOP) && stop_last && !brk_now;
      push_word = {ferr_acc | ~vote, perr_l, data_sh};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         par_l      <= P_NONE;
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         prev       <= 1'b1;
         div_cnt    <= '0;
         div_l      <= 16'd1;
         phase      <= '0;
         s_lo       <= 1'b1;
         s_mid      <= 1'b1;
         nb_l       <= 4'd8;
         bit_idx    <= '0;
         two_stop_l <= 1'b0;
         stop_idx   <= 1'b0;
         ferr_acc   <= 1'b0;
         perr_l     <= 1'b0;
         par_zero   <= 1'b1;
         data_sh    <= '0;
         break_det  <= 1'b0;
      end else begin
         sync1     <= uart_rx;
         sync2     <= sync1;
         prev      <= sync2;
         break_det <= 1'b0;
         if (state == S_IDLE) begin
            if (prev && !sync2) begin
               state      <= S_START;
               phase      <= '0;
               div_cnt    <= '0;
               div_l      <= (cfg_clk_div == 16'd0) ? 16'd1 : cfg_clk_div;
               nb_l       <= nb_c;
               par_l      <= (cfg_parity > 3'd4) ? P_NONE : par_t'(cfg_parity);
               two_stop_l <= cfg_stop_bits[1];
               data_sh    <= '0;
               bit_idx    <= '0;
               stop_idx   <= 1'b0;
               ferr_acc   <= 1'b0;
               perr_l     <= 1'b0;
               par_zero   <= 1'b1;
            end
         end else if (state == S_BREAK) begin
            if (sync2) state <= S_IDLE;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + 16'd1;
            if (tick) begin
               phase <= (phase == PH_END) ? '0 : phase + PW'(1);
               if (phase == PH_LO)  s_lo  <= sync2;
               if (phase == PH_MID) s_mid <= sync2;
            end
            // The state advances at the mid-bit decision; the phase counter keeps
            // running so the next decision lands mid-way through the following bit.
            if (decide) begin
               case (state)
                  S_START: state <= vote ? S_IDLE : S_DATA;
                  S_DATA: begin
                     data_sh[bit_idx] <= vote;
                     if (bit_idx == nb_l - 4'd1) begin
                        bit_idx <= '0;
                        state   <= (par_l == P_NONE) ? S_STOP : S_PARITY;
                     end else begin
                        bit_idx <= bit_idx + 4'd1;
                     end
                  end
                  S_PARITY: begin
                     par_zero <= ~vote;
                     case (par_l)
                        P_EVEN:  perr_l <= (^data_sh) ^ vote;
                        P_ODD:   perr_l <= ~((^data_sh) ^ vote);
                        P_MARK:  perr_l <= ~vote;
                        P_SPACE: perr_l <= vote;
                        default: perr_l <= 1'b0;
                     endcase
                     state <= S_STOP;
                  end
                  S_STOP: begin
                     if (brk_now) begin
                        break_det <= 1'b1;
                        state     <= S_BREAK;
                     end else if (stop_last) begin
                        state <= S_IDLE;
                     end else begin
                        stop_idx <= 1'b1;
                        ferr_acc <= ~vote;
                     end
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

   always_comb begin
      full    = (count == CW'(FIFO_DEPTH));
      pop     = rx_req && (count != '0);
      push_ok = push && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= push && full && !pop;
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem[wr_ptr] <= push_word;
   end

   always_comb begin
      head        = mem[rd_ptr];
      rx_ready    = (count != '0);
      rx_data     = rx_ready ? head[MAX_WIDTH-1:0] : '0;
      parity_err  = rx_ready & head[MAX_WIDTH];
      framing_err = rx_ready & head[MAX_WIDTH+1];
      rx_busy     = (state != S_IDLE);
   end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: frame-level model plus FIFO queue,
// compared against the DUT every cycle, with literal spot checks.
module tb_uart_rx_ext;

   localparam int MW    = 9;
   localparam int SR    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    cfg_data_bits = 4'd8;
   logic [2:0]    cfg_parity    = 3'd0;
   logic [1:0]    cfg_stop_bits = 2'd0;
   logic [15:0]   cfg_clk_div   = 16'd8;
   logic          uart_rx = 1'b1;
   logic          rx_req  = 1'b0;
   logic [MW-1:0] rx_data;
   logic          rx_ready, parity_err, framing_err, break_det, overrun, rx_busy;

   always #5 clk = ~clk;

   uart_rx_ext #(.MAX_WIDTH(MW), .SAMPLE_RATE(SR), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
      .cfg_stop_bits(cfg_stop_bits), .cfg_clk_div(cfg_clk_div), .uart_rx(uart_rx),
      .rx_req(rx_req), .rx_data(rx_data), .rx_ready(rx_ready), .parity_err(parity_err),
      .framing_err(framing_err), .break_det(break_det), .overrun(overrun), .rx_busy(rx_busy)
   );

   typedef struct {int data; bit perr; bit ferr;} word_t;
   typedef struct {int d; int nb; int par; int stop;} vec_t;

   int    passed = 0, total = 0;
   int    cyc = 0;
   word_t q[$];
   bit    pend_valid = 0;
   int    pend_due = 0;
   word_t pend_w;
   int    last_due = -100;
   int    frame_start = 0, rise_cyc = 0;
   bit    ready_q = 0;
   int    exp_breaks = 0, exp_overrun = 0, brk_seen = 0, ovr_seen = 0;
   bit    chk_en = 0;

   vec_t vecs[5] = '{'{'h5A, 8, 2, 0}, '{'h13, 6, 3, 1}, '{'h0F, 5, 4, 2},
                     '{'h1A5, 15, 1, 3}, '{'h2B, 8, 6, 0}};

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic bit exp_par(input int pm, input int d);
      case (pm)
         1: return ^d;
         2: return ~(^d);
         3: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Model FIFO: words land on the stop-bit decision cycle computed per frame.
   always @(posedge clk) begin : model
      int sz;
      bit popm;
      cyc = cyc + 1;
      if (rst) begin
         q.delete();
         pend_valid = 0;
      end else begin
         sz   = q.size();
         popm = rx_req && (sz > 0);
         if (popm) void'(q.pop_front());
         if (pend_valid && cyc == pend_due) begin
            pend_valid = 0;
            if (sz == DEPTH && !popm) exp_overrun++;
            else q.push_back(pend_w);
         end
      end
   end

   always @(negedge clk) begin : compare
      if (chk_en && !rst) begin
         if (break_det) brk_seen++;
         if (overrun) ovr_seen++;
         if (rx_ready && !ready_q) rise_cyc = cyc;
         ready_q = rx_ready;
         if (cyc + 2 < last_due || cyc > last_due + 2) begin
            chk("rx_ready", rx_ready, q.size() != 0);
            if (q.size() != 0) begin
               chk("rx_data", rx_data, q[0].data);
               chk("parity_err", parity_err, q[0].perr);
               chk("framing_err", framing_err, q[0].ferr);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pop();
      @(posedge clk); #1 rx_req = 1'b1;
      @(posedge clk); #1 rx_req = 1'b0;
   endtask

   task automatic send_frame(input int d, input int nb_cfg, input int par_cfg, input int stop_cfg,
                             input int div_cfg, input bit flip_par, input bit stop_low);
      int nb, pm, ns, dv, dm, n;
      bit pb, brk;
      bit bits[20];
      nb = (nb_cfg < 5) ? 5 : (nb_cfg > MW) ? MW : nb_cfg;
      pm = (par_cfg > 4) ? 0 : par_cfg;
      ns = (stop_cfg >= 2) ? 2 : 1;
      dv = (div_cfg == 0) ? 1 : div_cfg;
      dm = d & ((1 << nb) - 1);
      pb = exp_par(pm, dm) ^ flip_par;
      n = 0;
      bits[n] = 1'b0; n++;
      for (int i = 0; i < nb; i++) begin bits[n] = dm[i]; n++; end
      if (pm != 0) begin bits[n] = pb; n++; end
      bits[n] = !stop_low; n++;
      if (ns == 2) begin bits[n] = 1'b1; n++; end
      brk = (dm == 0) && (pm == 0 || pb == 1'b0) && stop_low;
      cfg_data_bits = 4'(nb_cfg);
      cfg_parity    = 3'(par_cfg);
      cfg_stop_bits = 2'(stop_cfg);
      cfg_clk_div   = 16'(div_cfg);
      @(posedge clk); #1;
      frame_start = cyc;
      if (brk) exp_breaks++;
      else begin
         pend_w.data = dm;
         pend_w.perr = (pm != 0) && (pb != exp_par(pm, dm));
         pend_w.ferr = stop_low;
         // 2-cycle synchroniser + edge detect, then mid-sample of the last stop bit.
         pend_due   = cyc + 3 + ((n - 1) * SR + SR / 2 + 2) * dv;
         pend_valid = 1;
         last_due   = pend_due;
      end
      for (int i = 0; i < n; i++) begin
         uart_rx = bits[i];
         repeat (SR * dv) @(posedge clk);
         #1;
      end
      uart_rx = 1'b1;
   endtask

   initial begin
      int b0, o0, lat;
      idle(4);
      rst = 1'b0;
      chk("reset_rx_ready", rx_ready, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_parity_err", parity_err, 0);
      chk("reset_framing_err", framing_err, 0);
      chk("reset_break_det", break_det, 0);
      chk("reset_overrun", overrun, 0);
      chk("reset_rx_busy", rx_busy, 0);
      chk_en = 1;

      // 8N1 at div 54
      send_frame('hA5, 8, 0, 0, 54, 0, 0);
      idle(2);
      lat = rise_cyc - frame_start;
      chk("t1_latency_in_window", (lat > 9 * 864 + 432) && (lat < 10 * 864), 1);
      chk("t1_data", rx_data, 'h0A5);
      chk("t1_perr", parity_err, 0);
      chk("t1_ferr", framing_err, 0);
      pop();

      // 7E2 with inverted parity bit
      send_frame('h41, 7, 1, 2, 8, 1, 0);
      idle(2);
      chk("t2_data", rx_data, 'h041);
      chk("t2_perr", parity_err, 1);
      chk("t2_ferr", framing_err, 0);
      pop();

      // stop bit low on a non-zero word
      b0 = brk_seen;
      send_frame('h3C, 8, 0, 0, 8, 0, 1);
      idle(2);
      chk("t3_data", rx_data, 'h03C);
      chk("t3_ferr", framing_err, 1);
      chk("t3_perr", parity_err, 0);
      chk("t3_no_break", brk_seen - b0, 0);
      pop();

      foreach (vecs[i]) begin
         send_frame(vecs[i].d, vecs[i].nb, vecs[i].par, vecs[i].stop, 8, 0, 0);
         idle(2);
         chk("vec_ready", rx_ready, 1);
         pop();
      end

      // line held low for two frame times
      b0 = brk_seen;
      @(posedge clk); #1 uart_rx = 1'b0;
      exp_breaks++;
      idle(20 * SR * 8);
      uart_rx = 1'b1;
      idle(2 * SR * 8);
      chk("t4_busy_after_break", rx_busy, 0);
      chk("t4_no_word", rx_ready, 0);
      send_frame('h55, 8, 0, 0, 8, 0, 0);
      idle(2);
      chk("t4_break_pulses", brk_seen - b0, 1);
      chk("t4_data", rx_data, 'h055);
      chk("t4_flags", {parity_err, framing_err}, 0);
      pop();

      // five words into a four-deep FIFO
      o0 = ovr_seen;
      for (int i = 0; i < 5; i++) send_frame(i, 8, 0, 0, 8, 0, 0);
      idle(4);
      chk("t5_overrun_pulses", ovr_seen - o0, 1);
      for (int i = 0; i < 4; i++) begin
         chk("t5_pop_data", rx_data, i);
         pop();
      end
      chk("t5_empty", rx_ready, 0);
      pop();
      chk("t5_pop_empty", rx_ready, 0);

      // two-tick glitch
      @(posedge clk); #1 uart_rx = 1'b0;
      idle(2 * 8);
      uart_rx = 1'b1;
      chk("t6_glitch_busy", rx_busy, 1);
      idle(2 * SR * 8);
      chk("t6_glitch_idle", rx_busy, 0);
      chk("t6_glitch_no_word", rx_ready, 0);

      // reset in the middle of a frame with a word queued
      send_frame('h12, 8, 0, 0, 8, 0, 0);
      @(posedge clk); #1 uart_rx = 1'b0;
      idle(3 * SR * 8);
      chk("t6_midframe_busy", rx_busy, 1);
      uart_rx = 1'b1;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      chk("t6_rst_ready", rx_ready, 0);
      chk("t6_rst_busy", rx_busy, 0);
      idle(1500);
      chk("t6_rst_no_word", rx_ready, 0);
      send_frame('h9, 5, 0, 0, 0, 0, 0);
      idle(2);
      chk("t6_after_rst_ready", rx_ready, 1);
      chk("t6_after_rst_data", rx_data, 'h009);
      pop();
      idle(4);

      chk("break_count", brk_seen, exp_breaks);
      chk("overrun_count", ovr_seen, exp_overrun);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
